// File: rtl/id_ex_stage_pkg.sv
// Shared core constants and types for the ID/EX stage: ALU opcodes,
// result sources, forward selects and the registered control bundle.
package id_ex_stage_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [2:0] alu_control;
        logic [1:0] result_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_write: 1'b0,
                                      branch: 1'b0, jump: 1'b0, alu_src: 1'b0,
                                      alu_control: ALU_ADD, result_src: RES_ALU};

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, forward sources and Execute-side outputs of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) ();
    logic            id_valid;
    logic [REGW-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rd1, id_rd2, id_imm, id_pc, id_pc_plus4;
    logic            id_alu_src;
    logic [2:0]      id_alu_control;
    logic            id_reg_write, id_mem_write, id_branch, id_jump;
    logic [1:0]      id_result_src;
    logic            flush_e;
    logic [REGW-1:0] mem_rd, wb_rd;
    logic            mem_reg_write, wb_reg_write;
    logic [XLEN-1:0] mem_alu_result, wb_result;

    logic [XLEN-1:0] ex_src_a, ex_src_b, ex_write_data;
    logic [2:0]      ex_alu_control;
    logic [REGW-1:0] ex_rd;
    logic [XLEN-1:0] ex_imm, ex_pc, ex_pc_plus4;
    logic            ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_valid;
    logic [1:0]      ex_result_src;
    logic            stall_f, stall_d;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc, id_pc_plus4,
               id_alu_src, id_alu_control, id_reg_write, id_mem_write, id_branch, id_jump,
               id_result_src, flush_e, mem_rd, mem_reg_write, mem_alu_result,
               wb_rd, wb_reg_write, wb_result,
        output ex_src_a, ex_src_b, ex_write_data, ex_alu_control, ex_rd, ex_imm, ex_pc,
               ex_pc_plus4, ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_valid,
               ex_result_src, stall_f, stall_d
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc, id_pc_plus4,
               id_alu_src, id_alu_control, id_reg_write, id_mem_write, id_branch, id_jump,
               id_result_src, flush_e, mem_rd, mem_reg_write, mem_alu_result,
               wb_rd, wb_reg_write, wb_result,
        input  ex_src_a, ex_src_b, ex_write_data, ex_alu_control, ex_rd, ex_imm, ex_pc,
               ex_pc_plus4, ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_valid,
               ex_result_src, stall_f, stall_d
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source operand forwarding: MEM beats WB beats register file; x0 never forwards.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_data,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);
    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && mem_rd != '0 && mem_rd == rs)
            sel = FWD_MEM;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == rs)
            sel = FWD_WB;
    end

    always_comb begin
        case (sel)
            FWD_MEM: data = mem_data;
            FWD_WB:  data = wb_data;
            default: data = rf_data;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall/bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    ctrl_t                     ctrl_q;
    logic [1:0][REGW-1:0]      rs_q;
    logic [1:0][XLEN-1:0]      rf_q;
    logic [1:0][XLEN-1:0]      fwd;
    logic [REGW-1:0]           rd_q;
    logic [XLEN-1:0]           imm_q, pc_q, pc4_q;
    logic                      load_use, bubble;

    assign load_use = ctrl_q.valid && ctrl_q.result_src == RES_MEM && rd_q != '0 &&
                      (rd_q == bus.id_rs1 || rd_q == bus.id_rs2) && bus.id_valid;
    assign bubble   = reset || bus.flush_e || load_use || !bus.id_valid;

    always_ff @(posedge clk) begin
        if (bubble) begin
            ctrl_q <= CTRL_BUBBLE;
            rs_q   <= '0;
            rf_q   <= '0;
            rd_q   <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            pc4_q  <= '0;
        end else begin
            ctrl_q <= '{valid: 1'b1, reg_write: bus.id_reg_write, mem_write: bus.id_mem_write,
                        branch: bus.id_branch, jump: bus.id_jump, alu_src: bus.id_alu_src,
                        alu_control: bus.id_alu_control, result_src: bus.id_result_src};
            rs_q   <= {bus.id_rs2, bus.id_rs1};
            rf_q   <= {bus.id_rd2, bus.id_rd1};
            rd_q   <= bus.id_rd;
            imm_q  <= bus.id_imm;
            pc_q   <= bus.id_pc;
            pc4_q  <= bus.id_pc_plus4;
        end
    end

    // index 0 = rs1, index 1 = rs2
    for (genvar g = 0; g < 2; g++) begin : g_fwd
        fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd (
            .rs            (rs_q[g]),
            .rf_data       (rf_q[g]),
            .mem_rd        (bus.mem_rd),
            .mem_reg_write (bus.mem_reg_write),
            .mem_data      (bus.mem_alu_result),
            .wb_rd         (bus.wb_rd),
            .wb_reg_write  (bus.wb_reg_write),
            .wb_data       (bus.wb_result),
            .data          (fwd[g])
        );
    end

    assign bus.ex_src_a       = fwd[0];
    assign bus.ex_write_data  = fwd[1];
    assign bus.ex_src_b       = ctrl_q.alu_src ? imm_q : fwd[1];
    assign bus.ex_alu_control = ctrl_q.alu_control;
    assign bus.ex_rd          = rd_q;
    assign bus.ex_imm         = imm_q;
    assign bus.ex_pc          = pc_q;
    assign bus.ex_pc_plus4    = pc4_q;
    assign bus.ex_reg_write   = ctrl_q.reg_write;
    assign bus.ex_mem_write   = ctrl_q.mem_write;
    assign bus.ex_branch      = ctrl_q.branch;
    assign bus.ex_jump        = ctrl_q.jump;
    assign bus.ex_valid       = ctrl_q.valid;
    assign bus.ex_result_src  = ctrl_q.result_src;

    // A redirect wins over a load-use stall so the new fetch is not held.
    assign bus.stall_f = load_use && !bus.flush_e;
    assign bus.stall_d = load_use && !bus.flush_e;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against a behavioural instruction-level model.
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    id_ex_stage_if #(.XLEN(32), .REGW(5)) bus ();

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction currently held in EX, as the model sees it.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic        alu_src;
        logic [2:0]  alu_ctl;
        logic        rw, mw, br, jp;
        logic [1:0]  rsrc;
    } instr_t;

    instr_t m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf);
        if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == rs) return bus.mem_alu_result;
        if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == rs) return bus.wb_result;
        return rf;
    endfunction

    task automatic check_outputs();
        logic [31:0] a, wd;
        a  = fwd_val(m.rs1, m.rd1);
        wd = fwd_val(m.rs2, m.rd2);
        check("src_a", bus.ex_src_a, a);
        check("write_data", bus.ex_write_data, wd);
        check("src_b", bus.ex_src_b, m.alu_src ? m.imm : wd);
        check("alu_control", {29'd0, bus.ex_alu_control}, {29'd0, m.alu_ctl});
        check("rd", {27'd0, bus.ex_rd}, {27'd0, m.rd});
        check("imm", bus.ex_imm, m.imm);
        check("pc", bus.ex_pc, m.pc);
        check("pc_plus4", bus.ex_pc_plus4, m.pc4);
        check("ctrl", {27'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write, bus.ex_branch, bus.ex_jump},
              {27'd0, m.valid, m.rw, m.mw, m.br, m.jp});
        check("result_src", {30'd0, bus.ex_result_src}, {30'd0, m.rsrc});
    endtask

    // One clock: check stall before the edge, advance model, check EX outputs after.
    task automatic cycle();
        logic lu, bub;
        #1;
        lu = m.valid && m.rsrc == 2'b01 && m.rd != 0 &&
             (m.rd == bus.id_rs1 || m.rd == bus.id_rs2) && bus.id_valid;
        check("stall_f", {31'd0, bus.stall_f}, {31'd0, lu && !bus.flush_e});
        check("stall_d", {31'd0, bus.stall_d}, {31'd0, lu && !bus.flush_e});
        bub = reset || bus.flush_e || lu || !bus.id_valid;
        @(posedge clk);
        if (bub) m = '0;
        else begin
            m.valid = 1'b1;
            m.rs1 = bus.id_rs1;  m.rs2 = bus.id_rs2;  m.rd = bus.id_rd;
            m.rd1 = bus.id_rd1;  m.rd2 = bus.id_rd2;  m.imm = bus.id_imm;
            m.pc = bus.id_pc;    m.pc4 = bus.id_pc_plus4;
            m.alu_src = bus.id_alu_src;  m.alu_ctl = bus.id_alu_control;
            m.rw = bus.id_reg_write;  m.mw = bus.id_mem_write;
            m.br = bus.id_branch;     m.jp = bus.id_jump;
            m.rsrc = bus.id_result_src;
        end
        #1;
        check_outputs();
    endtask

    task automatic rand_id();
        bus.id_valid       = ($urandom_range(0, 7) != 0);
        bus.id_rs1         = 5'($urandom_range(0, 7));
        bus.id_rs2         = 5'($urandom_range(0, 7));
        bus.id_rd          = 5'($urandom_range(0, 7));
        bus.id_rd1         = $urandom;
        bus.id_rd2         = $urandom;
        bus.id_imm         = $urandom;
        bus.id_pc          = $urandom;
        bus.id_pc_plus4    = bus.id_pc + 32'd4;
        bus.id_alu_src     = 1'($urandom);
        bus.id_alu_control = 3'($urandom);
        bus.id_reg_write   = 1'($urandom);
        bus.id_mem_write   = 1'($urandom);
        bus.id_branch      = 1'($urandom);
        bus.id_jump        = 1'($urandom);
        bus.id_result_src  = 2'($urandom_range(0, 2));
    endtask

    task automatic rand_fwd();
        bus.mem_rd         = 5'($urandom_range(0, 7));
        bus.mem_reg_write  = 1'($urandom);
        bus.mem_alu_result = $urandom;
        bus.wb_rd          = 5'($urandom_range(0, 7));
        bus.wb_reg_write   = 1'($urandom);
        bus.wb_result      = $urandom;
    endtask

    task automatic no_fwd();
        bus.mem_rd = 0;  bus.mem_reg_write = 0;  bus.mem_alu_result = 0;
        bus.wb_rd  = 0;  bus.wb_reg_write  = 0;  bus.wb_result      = 0;
    endtask

    // A plain valid ALU instruction with no dependencies on anything in flight.
    task automatic plain_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [1:0] rsrc);
        rand_id();
        bus.id_valid = 1'b1;
        bus.id_rs1 = rs1;  bus.id_rs2 = rs2;  bus.id_rd = rd;
        bus.id_result_src = rsrc;
        bus.id_alu_src = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m = '0;
        bus.flush_e = 1'b0;
        no_fwd();
        rand_id();
        reset = 1'b1;

        // Reset with random Decode inputs
        cycle();
        rand_id();
        cycle();
        check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_src_a", bus.ex_src_a, 32'd0);
        check("rst_stall", {30'd0, bus.stall_f, bus.stall_d}, 32'd0);
        reset = 1'b0;

        // MEM forward onto rs1
        plain_id(5'd5, 5'd0, 5'd6, 2'b00);
        bus.id_rd1 = 32'h0;
        bus.mem_rd = 5'd5;  bus.mem_reg_write = 1'b1;  bus.mem_alu_result = 32'h0000_0010;
        cycle();
        check("mem_fwd_a", bus.ex_src_a, 32'h0000_0010);

        // MEM beats WB on rs2
        plain_id(5'd0, 5'd7, 5'd8, 2'b00);
        bus.id_rd1 = 32'hDEAD_BEEF;
        bus.mem_rd = 5'd7;  bus.mem_alu_result = 32'hAAAA_0000;
        bus.wb_rd  = 5'd7;  bus.wb_reg_write = 1'b1;  bus.wb_result = 32'h5555_0000;
        cycle();
        check("prio_src_b", bus.ex_src_b, 32'hAAAA_0000);

        // x0 never forwarded even with mem_rd = 0 writing
        bus.mem_rd = 5'd0;  bus.wb_rd = 5'd0;
        #1;
        check("x0_src_a", bus.ex_src_a, 32'hDEAD_BEEF);
        no_fwd();

        // Load-use: lw x3 then consumer of x3
        plain_id(5'd1, 5'd2, 5'd3, 2'b01);
        cycle();
        plain_id(5'd1, 5'd3, 5'd4, 2'b00);
        #1;
        check("lu_stall_f", {31'd0, bus.stall_f}, 32'd1);
        check("lu_stall_d", {31'd0, bus.stall_d}, 32'd1);
        cycle();
        check("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
        cycle();
        check("lu_dep_in", {27'd0, bus.ex_valid, bus.ex_rd}, {27'd0, 1'b1, 5'd4});

        // Flush with load-use: bubble, no stall
        plain_id(5'd0, 5'd0, 5'd9, 2'b01);
        cycle();
        plain_id(5'd9, 5'd0, 5'd10, 2'b00);
        bus.flush_e = 1'b1;
        #1;
        check("fl_stall", {30'd0, bus.stall_f, bus.stall_d}, 32'd0);
        cycle();
        check("fl_bubble", {31'd0, bus.ex_valid}, 32'd0);
        bus.flush_e = 1'b0;

        // Immediate selects operand B; store data still follows rs2
        plain_id(5'd0, 5'd2, 5'd11, 2'b00);
        bus.id_alu_src = 1'b1;  bus.id_alu_control = 3'b000;
        bus.id_imm = 32'hFFFF_FFFC;  bus.id_rd2 = 32'h0000_1234;
        cycle();
        check("imm_src_b", bus.ex_src_b, 32'hFFFF_FFFC);
        check("imm_wdata", bus.ex_write_data, 32'h0000_1234);

        // Reset asserted during a load-use stall
        plain_id(5'd0, 5'd0, 5'd12, 2'b01);
        cycle();
        plain_id(5'd12, 5'd0, 5'd13, 2'b00);
        reset = 1'b1;
        cycle();
        check("rst_mid_stall", {29'd0, bus.ex_valid, bus.stall_f, bus.stall_d}, 32'd0);
        reset = 1'b0;

        // Back-to-back dependent loads: one bubble each
        plain_id(5'd0, 5'd0, 5'd3, 2'b01);
        cycle();
        plain_id(5'd3, 5'd0, 5'd4, 2'b01);
        cycle();
        check("b2b_bub1", {31'd0, bus.ex_valid}, 32'd0);
        cycle();
        plain_id(5'd0, 5'd4, 5'd5, 2'b00);
        cycle();
        check("b2b_bub2", {31'd0, bus.ex_valid}, 32'd0);
        cycle();
        check("b2b_in", {31'd0, bus.ex_valid}, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rand_fwd();
            bus.flush_e = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
